mfa_expand: RTL and testbench

//  Decoder side of index compression: re-expands data blocks whose most frequently

---
 rtl/mfa_expand_pkg.sv | 45 ++++
 rtl/mfa_expand_insert.sv | 44 ++++
 rtl/mfa_expand.sv | 178 +++++++++++++++++
 tb/tb_mfa_expand.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfa_expand_pkg.sv
// Types and constants for the MFA expander. The token layout and attribute field
// positions are shared with the store-side controller.
package mfa_expand_pkg;

  localparam int NUM_IDS_DEF   = 3;
  localparam int WIDTH_CNT_DEF = 16;
  localparam int WIDTH_DATA    = 32;
  localparam int POSIT_SHARED  = 31;
  localparam int ATTR_LEN_LSB  = 0;

  typedef struct packed {
    logic                  v;
    logic                  a;
    logic                  r;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;

  typedef enum logic [3:0] {
    EXP_INIT,
    EXP_IDS,
    EXP_ATTRIB,
    EXP_SHARED,
    EXP_MASK,
    EXP_DATA,
    EXP_BYPASS,
    EXP_WAITRLS,
    EXP_TERM
  } fsm_mfa_exp;

  function automatic logic tok_acquire(input FTk_t t);
    return t.v & t.a;
  endfunction

  function automatic logic tok_release(input FTk_t t);
    return t.v & t.r;
  endfunction

endpackage

// File: rtl/mfa_expand_insert.sv
// Shared-value insertion path: holds shared word and mask, walks the mask bit index k,
// and selects shared value vs forwarded input word. Combinational select, registered state.
module mfa_expand_insert
  import mfa_expand_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ld_sdata,
  input  logic                  ld_mask,
  input  logic                  step,
  input  logic [WIDTH_DATA-1:0] in_dat,
  output logic [WIDTH_DATA-1:0] sel_dat,
  output logic                  mask_bit,
  output logic                  k_last
);

  localparam int KW = $clog2(WIDTH_DATA);
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH_DATA - 1);

  logic [WIDTH_DATA-1:0] r_sdata;
  logic [WIDTH_DATA-1:0] r_mask;
  logic [KW-1:0]         k;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sdata <= '0;
      r_mask  <= '0;
      k       <= '0;
    end else begin
      if (ld_sdata) r_sdata <= in_dat;
      if (ld_mask) begin
        r_mask <= in_dat;
        k      <= '0;
      end else if (step) begin
        k <= k + KW'(1);
      end
    end
  end

  assign mask_bit = r_mask[k];
  assign k_last   = (k == K_LAST);
  assign sel_dat  = mask_bit ? r_sdata : in_dat;

endmodule

// File: rtl/mfa_expand.sv
// MFA decoder: strips shared/mask words and re-inserts the shared value at masked positions.
// Output registered (1 cycle); I_BTk.n freezes output and FSM; inserts nack the input side.
module mfa_expand
  import mfa_expand_pkg::*;
#(
  parameter int NUM_IDS   = NUM_IDS_DEF,
  parameter int WIDTH_CNT = WIDTH_CNT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  FTk_t I_FTk,
  output BTk_t O_BTk,
  output FTk_t O_FTk,
  input  BTk_t I_BTk,
  output logic O_Busy,
  output logic O_End,
  output logic O_Err
);

  localparam logic [7:0] ID_LAST = 8'(NUM_IDS - 1);

  fsm_mfa_exp state, next_state;

  logic                  stall, insert, take, rls;
  logic                  mask_bit, k_last;
  logic [WIDTH_DATA-1:0] sel_dat;
  logic [WIDTH_CNT-1:0]  cnt, len, cnt_inc;
  logic                  cnt_hit;
  logic [7:0]            id_cnt;

  FTk_t emit_tok;
  logic ld_len, ld_sdata, ld_mask, step, set_err, id_inc;

  assign stall   = I_BTk.n;
  assign insert  = (state == EXP_DATA) && mask_bit;
  // TERM also refuses input so a back-to-back acquire is not swallowed.
  assign O_BTk.n = I_BTk.n | insert | (state == EXP_TERM);
  assign O_BTk.t = I_BTk.t;
  assign O_BTk.v = I_BTk.v;
  assign O_BTk.c = I_BTk.c;
  assign take    = I_FTk.v & ~O_BTk.n;
  assign rls     = take & tok_release(I_FTk);
  assign cnt_inc = cnt + WIDTH_CNT'(1);
  assign cnt_hit = (cnt_inc == len);

  assign O_Busy = (state != EXP_INIT);
  assign O_End  = (state == EXP_TERM);

  mfa_expand_insert u_insert (
    .clock    (clock),
    .reset    (reset),
    .ld_sdata (ld_sdata),
    .ld_mask  (ld_mask),
    .step     (step),
    .in_dat   (I_FTk.d),
    .sel_dat  (sel_dat),
    .mask_bit (mask_bit),
    .k_last   (k_last)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= EXP_INIT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      EXP_INIT:
        if (take && tok_acquire(I_FTk))
          next_state = (NUM_IDS == 1) ? EXP_ATTRIB : EXP_IDS;
      EXP_IDS:
        if (rls)                          next_state = EXP_TERM;
        else if (take && id_cnt == ID_LAST) next_state = EXP_ATTRIB;
      EXP_ATTRIB:
        if (rls)       next_state = EXP_TERM;
        else if (take) next_state = I_FTk.d[POSIT_SHARED] ? EXP_SHARED : EXP_BYPASS;
      EXP_SHARED:
        if (rls)       next_state = EXP_TERM;
        else if (take) next_state = (len == '0) ? EXP_WAITRLS : EXP_MASK;
      EXP_MASK:
        if (rls)       next_state = EXP_TERM;
        else if (take) next_state = EXP_DATA;
      EXP_DATA:
        if (mask_bit ? !stall : take) begin
          if (!mask_bit && I_FTk.r) next_state = EXP_TERM;
          else if (cnt_hit)         next_state = EXP_WAITRLS;
          else if (k_last)          next_state = EXP_MASK;
        end
      EXP_BYPASS:  if (rls) next_state = EXP_TERM;
      EXP_WAITRLS: if (rls) next_state = EXP_TERM;
      EXP_TERM:    next_state = EXP_INIT;
      default:     next_state = EXP_INIT;
    endcase
  end

  always_comb begin
    emit_tok = '0;
    ld_len   = 1'b0;
    ld_sdata = 1'b0;
    ld_mask  = 1'b0;
    step     = 1'b0;
    set_err  = 1'b0;
    id_inc   = 1'b0;
    case (state)
      EXP_INIT:
        if (take && tok_acquire(I_FTk)) begin
          emit_tok = I_FTk;
          id_inc   = 1'b1;
        end
      EXP_IDS:
        if (take) begin
          emit_tok = I_FTk;
          set_err  = I_FTk.r;
          id_inc   = ~I_FTk.r;
        end
      EXP_ATTRIB:
        if (take) begin
          emit_tok = I_FTk;
          if (I_FTk.r) set_err = 1'b1;
          else begin
            ld_len                  = 1'b1;
            emit_tok.d[POSIT_SHARED] = 1'b0;
          end
        end
      EXP_SHARED, EXP_MASK:
        if (take) begin
          if (I_FTk.r) begin
            emit_tok = I_FTk;
            set_err  = 1'b1;
          end else begin
            ld_sdata = (state == EXP_SHARED);
            ld_mask  = (state == EXP_MASK);
          end
        end
      EXP_DATA:
        if (mask_bit) begin
          if (!stall) begin
            emit_tok.v = 1'b1;
            emit_tok.d = sel_dat;
            step       = 1'b1;
          end
        end else if (take) begin
          emit_tok = I_FTk;
          set_err  = I_FTk.r;
          step     = ~I_FTk.r;
        end
      EXP_BYPASS:  if (take) emit_tok = I_FTk;
      EXP_WAITRLS: if (rls)  emit_tok = I_FTk;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      O_FTk  <= '0;
      cnt    <= '0;
      len    <= '0;
      id_cnt <= '0;
      O_Err  <= 1'b0;
    end else begin
      if (!stall) O_FTk <= emit_tok;
      if (ld_len) begin
        len <= I_FTk.d[ATTR_LEN_LSB +: WIDTH_CNT];
        cnt <= '0;
      end else if (step) begin
        cnt <= cnt_inc;
      end
      if (id_inc) id_cnt <= (state == EXP_INIT) ? 8'd1 : id_cnt + 8'd1;
      if (state == EXP_TERM) begin
        id_cnt <= '0;
        cnt    <= '0;
      end
      if (set_err) O_Err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mfa_expand.sv
// Randomized bench for mfa_expand: a block-level expansion model builds the input and
// expected output streams; one monitor compares every delivered output token.
module tb_mfa_expand;
  import mfa_expand_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  FTk_t I_FTk, O_FTk;
  BTk_t I_BTk, O_BTk;
  logic O_Busy, O_End, O_Err;

  mfa_expand dut (
    .clock (clock), .reset (reset),
    .I_FTk (I_FTk), .O_BTk (O_BTk),
    .O_FTk (O_FTk), .I_BTk (I_BTk),
    .O_Busy(O_Busy), .O_End(O_End), .O_Err(O_Err)
  );

  always #5 clock = ~clock;

  int   total = 0, bad = 0;
  int   cyc = 0;
  int   end_cnt = 0, end_base = 0;
  int   t_acq = -100;
  int   stall_pct = 0, bubble_pct = 0, force_until = 0;
  logic err_sticky = 1'b0;
  FTk_t in_q[$];
  FTk_t exp_q[$];
  logic [WIDTH_DATA-1:0] mask_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  // Block-level reference: expands element by element from the stated rules.
  task automatic build_block(input bit shared, input int len, input logic [31:0] sval,
                             input int keep, input int junk, input logic [31:0] dbase,
                             input logic [31:0] id0);
    FTk_t t;
    logic [31:0] m;
    int used, di, emitted;
    bit stop;
    for (int i = 0; i < 3; i++) begin
      t = '0; t.v = 1'b1; t.a = (i == 0); t.d = id0 + 32'(i);
      in_q.push_back(t); exp_q.push_back(t);
    end
    t = '0; t.v = 1'b1; t.d = 32'(len) & 32'h0000_FFFF; t.d[31] = shared;
    in_q.push_back(t);
    t.d[31] = 1'b0;
    exp_q.push_back(t);
    emitted = 0; di = 0; used = 0; stop = 0;
    if (!shared) begin
      for (int i = 0; i < len; i++) begin
        t = '0; t.v = 1'b1; t.d = dbase + 32'(i);
        in_q.push_back(t); exp_q.push_back(t);
      end
    end else begin
      t = '0; t.v = 1'b1; t.d = sval;
      in_q.push_back(t);
      for (int g = 0; emitted < len && !stop; g++) begin
        if (keep >= 0 && used == keep) stop = 1;
        else begin
          m = (g < mask_q.size()) ? mask_q[g] : $urandom();
          t = '0; t.v = 1'b1; t.d = m;
          in_q.push_back(t); used++;
          for (int b = 0; b < 32 && emitted < len; b++) begin
            if (m[b]) begin
              t = '0; t.v = 1'b1; t.d = sval;
              exp_q.push_back(t); emitted++;
            end else if (keep >= 0 && used == keep) begin
              stop = 1;
              break;
            end else begin
              t = '0; t.v = 1'b1; t.d = dbase + 32'(di);
              in_q.push_back(t); exp_q.push_back(t);
              di++; used++; emitted++;
            end
          end
        end
      end
      if (emitted == len)
        for (int j = 0; j < junk; j++) begin
          t = '0; t.v = 1'b1; t.d = $urandom();
          in_q.push_back(t);
        end
      else
        err_sticky = 1'b1;
    end
    t = '0; t.v = 1'b1; t.r = 1'b1; t.d = $urandom();
    in_q.push_back(t); exp_q.push_back(t);
    mask_q.delete();
  endtask

  // Upstream driver and downstream back-pressure.
  initial begin
    bit took;
    I_FTk = '0; I_BTk = '0;
    forever begin
      @(negedge clock);
      took = I_FTk.v && !O_BTk.n && !reset;
      if (took && I_FTk.a) t_acq = cyc + 1;
      @(posedge clock); #1;
      if (took && in_q.size() > 0) void'(in_q.pop_front());
      if (in_q.size() > 0 && ((I_FTk.v && !took) || $urandom_range(99) >= bubble_pct))
        I_FTk = in_q[0];
      else
        I_FTk = '0;
      I_BTk.n = (cyc < force_until) || ($urandom_range(99) < stall_pct);
      I_BTk.t = 1'($urandom_range(1));
      I_BTk.v = 1'($urandom_range(1));
      I_BTk.c = 1'($urandom_range(1));
    end
  end

  // Compare process.
  initial begin
    FTk_t e;
    bit seen = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        total++;
        if (O_BTk.t !== I_BTk.t || O_BTk.v !== I_BTk.v || O_BTk.c !== I_BTk.c ||
            (I_BTk.n && !O_BTk.n)) begin
          bad++;
          $display("FAIL btk_pass: got %b required n>=%b t/v/c=%b%b%b", O_BTk, I_BTk.n,
                   I_BTk.t, I_BTk.v, I_BTk.c);
        end
        if (O_FTk.v && O_FTk.a) begin
          if (!seen) begin
            total++;
            if (cyc != t_acq) begin
              bad++;
              $display("FAIL latency: acquire out at cycle %0d required %0d", cyc, t_acq);
            end
          end
          seen = 1;
        end else seen = 0;
        if (O_FTk.v && !I_BTk.n) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_tok: got %h required no token", O_FTk);
          end else begin
            e = exp_q.pop_front();
            if (O_FTk !== e) begin
              bad++;
              $display("FAIL token: got %h required %h", O_FTk, e);
            end
          end
        end
        if (O_End) end_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #2;
    @(posedge clock); #2;
    in_q.delete(); exp_q.delete();
    err_sticky = 1'b0;
    reset = 1'b0;
    @(posedge clock); #2;
    end_base = end_cnt;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    int budget = 400 + 8 * (in_q.size() + exp_q.size());
    while (!(in_q.size() == 0 && exp_q.size() == 0 && !O_Busy) && c < budget) begin
      @(posedge clock); #2;
      c++;
    end
    total++;
    if (c >= budget) begin
      bad++;
      $display("FAIL %s_timeout: in_q=%0d exp_q=%0d busy=%0b required drained", name,
               in_q.size(), exp_q.size(), O_Busy);
      do_reset();
    end else begin
      check({name, "_end"}, 64'(end_cnt - end_base), 64'd1);
      check({name, "_err"}, 64'(O_Err), 64'(err_sticky));
    end
    end_base = end_cnt;
  endtask

  initial begin
    logic [31:0] pin2 [6];
    int target, c;
    pin2[0] = 1; pin2[1] = 32'h55; pin2[2] = 2; pin2[3] = 3; pin2[4] = 32'h55; pin2[5] = 4;

    repeat (2) @(posedge clock);
    #2;
    check("rst_ftk",  64'(O_FTk),  64'd0);
    check("rst_busy", 64'(O_Busy), 64'd0);
    check("rst_end",  64'(O_End),  64'd0);
    check("rst_err",  64'(O_Err),  64'd0);
    reset = 1'b0;
    @(posedge clock); #2;

    // 1: unshared pass-through
    build_block(0, 4, 0, -1, 0, 32'hA, 1);
    wait_done("t1_bypass");

    // 2: shared expansion, model pinned by hand-computed values
    mask_q.push_back(32'b010010);
    build_block(1, 6, 32'h55, -1, 0, 1, 1);
    check("t2_len", 64'(exp_q.size()), 64'd11);
    check("t2_attr", 64'(exp_q[3].d), 64'd6);
    for (int i = 0; i < 6; i++) check("t2_elem", 64'(exp_q[4 + i].d), 64'(pin2[i]));
    wait_done("t2_shared");

    // 3: all-ones group then partial group
    mask_q.push_back(32'hFFFF_FFFF); mask_q.push_back(32'b01);
    build_block(1, WIDTH_DATA + 2, 32'h5A5A_0001, -1, 1, 32'h0000_0BAD, 7);
    check("t3_len", 64'(exp_q.size()), 64'd39);
    check("t3_x", 64'(exp_q[37].d), 64'h0BAD);
    wait_done("t3_allones");

    // 4: test 2 with a 3-cycle downstream stall mid-group
    mask_q.push_back(32'b010010);
    build_block(1, 6, 32'h55, -1, 0, 1, 1);
    c = 0;
    while (exp_q.size() > 5 && c < 200) begin @(posedge clock); #2; c++; end
    force_until = cyc + 3;
    wait_done("t4_stall");

    // 5: early release after 2 of 6 elements
    do_reset();
    mask_q.push_back(32'h0);
    build_block(1, 6, 32'h55, 3, 0, 32'h20, 4);
    check("t5_len", 64'(exp_q.size()), 64'd7);
    wait_done("t5_early");
    check("t5_busy", 64'(O_Busy), 64'd0);

    // Early release with the largest legal LEN.
    build_block(1, 65535, 32'h77, 2, 0, 32'h30, 9);
    wait_done("len_max");

    // 6: reset while expanding data
    stall_pct = 15; bubble_pct = 15;
    mask_q.push_back(32'h0000_0F00);
    build_block(1, 40, 32'h66, -1, 0, 32'h40, 2);
    target = exp_q.size() - 10;
    c = 0;
    while (exp_q.size() > target && c < 500) begin @(posedge clock); #2; c++; end
    reset = 1'b1;
    @(posedge clock); #2;
    check("t6_ftk",  64'(O_FTk),  64'd0);
    check("t6_busy", 64'(O_Busy), 64'd0);
    in_q.delete(); exp_q.delete();
    err_sticky = 1'b0;
    reset = 1'b0;
    @(posedge clock); #2;
    end_base = end_cnt;
    mask_q.push_back(32'b010010);
    build_block(1, 6, 32'h55, -1, 0, 1, 1);
    wait_done("t6_after");

    // Random blocks.
    stall_pct = 20; bubble_pct = 20;
    for (int b = 0; b < 25; b++) begin
      bit sh;
      int ln, kp, r;
      sh = ($urandom_range(3) != 0);
      ln = ($urandom_range(4) == 0) ? $urandom_range(3) : $urandom_range(75, 8);
      kp = ($urandom_range(3) == 0) ? $urandom_range(6) : -1;
      for (int g = 0; g < 3; g++) begin
        r = $urandom_range(5);
        mask_q.push_back(r == 0 ? 32'h0 : r == 1 ? 32'hFFFF_FFFF : $urandom());
      end
      build_block(sh, ln, $urandom(), kp, $urandom_range(2), $urandom(), 32'h100 * b);
      wait_done("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
